// File: rtl/mem_access_arbiter.sv
// Purpose: shares one single-port memory array between two requesters and drives its rw/sleep controls.
// Latency: ack two cycles after a request seen in IDLE; from SLEEP WAKE_CYCLES+3 cycles.
// Backpressure: a requester holds req until its one-cycle ack; losers wait. Macro MEM_ARB_FIXED_PRIORITY_EN selects fixed priority.
module mem_access_arbiter #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rw,
  output logic              mem_sleep,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    ST_SLEEP  = 2'd0,
    ST_WAKE   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACCESS = 2'd3
  } state_t;

  // Idle counter must be able to hold IDLE_CYCLES; wake counter counts 0..WAKE_CYCLES-1.
  localparam int IC_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int WC_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IC_W-1:0] IDLE_LAST = IC_W'(IDLE_CYCLES);
  localparam logic [WC_W-1:0] WAKE_LAST = WC_W'(WAKE_CYCLES - 1);

  state_t          state;
  logic [IC_W-1:0] idle_cnt;
  logic [WC_W-1:0] wake_cnt;
  logic            win;
  logic            eff0;
  logic            eff1;
  logic            grant_vld;
  logic            grant_sel;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
  logic            rr_ptr;
`endif

  // Winner selection; a requester is masked during its own ack cycle so a held req is not re-granted.
  always_comb begin
    eff0 = req0 & ~ack0;
    eff1 = req1 & ~ack1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    // A held req0 (even while masked) keeps requester 1 out, so requester 0 owns the array while it asks.
    grant_vld = eff0 | (eff1 & ~req0);
    grant_sel = ~eff0;
`else
    grant_vld = eff0 | eff1;
    grant_sel = (eff0 & eff1) ? rr_ptr : eff1;
`endif
  end

  // Access sequencer and power FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state     <= ST_SLEEP;
      mem_sleep <= 1'b1;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      win       <= 1'b0;
      idle_cnt  <= '0;
      wake_cnt  <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_SLEEP: begin
          if (req0 | req1) begin
            state     <= ST_WAKE;
            mem_sleep <= 1'b0;
            wake_cnt  <= '0;
          end
        end
        ST_WAKE: begin
          if (wake_cnt == WAKE_LAST) begin
            state    <= ST_IDLE;
            wake_cnt <= '0;
            idle_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          // Timeout is checked first: a request arriving as the counter expires waits for the next wake.
          if ((IDLE_CYCLES != 0) && (idle_cnt == IDLE_LAST)) begin
            state     <= ST_SLEEP;
            mem_sleep <= 1'b1;
            idle_cnt  <= '0;
          end else if (grant_vld) begin
            state    <= ST_ACCESS;
            win      <= grant_sel;
            mem_rw   <= grant_sel ? we1 : we0;
            mem_addr <= grant_sel ? addr1 : addr0;
            mem_din  <= grant_sel ? wdata1 : wdata0;
            idle_cnt <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            rr_ptr   <= ~grant_sel;
`endif
          end else if (IDLE_CYCLES != 0) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_ACCESS: begin
          if (!mem_rw) begin
            rdata <= mem_dout;
          end
          ack0  <= ~win;
          ack1  <= win;
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_SLEEP;
          mem_sleep <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single-port memory array between two requesters.
- Sequences each access into the array's `rw`/`sleep` control interface.
- Manages power: the array sleeps after an idle timeout and wakes on demand.
- Sits between the two requesters and the memory array plus its control FSM.

Parameters:
- ADDR_W, 4, address width of the array.
- DATA_W, 8, data word width.
- IDLE_CYCLES, 4, consecutive idle cycles in IDLE before returning to SLEEP; 0 disables auto-sleep.
- WAKE_CYCLES, 2, cycles spent in WAKE before the first access after sleep; minimum 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- _rst  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 access request; held high until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read; stable while req0 is high.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  requester 1, same rules as requester 0.
- ack0  out  1  one-cycle completion pulse to requester 0.
- ack1  out  1  one-cycle completion pulse to requester 1.
- rdata  out  DATA_W  read data; valid in the ack cycle of a read, held until the next read completes.
- mem_rw  out  1  to array: 1 = write, 0 = read.
- mem_sleep  out  1  to array: 1 = power rails off.
- mem_addr  out  ADDR_W  to array address.
- mem_din  out  DATA_W  to array write data.
- mem_dout  in  DATA_W  from array read data, valid during ACCESS.

Behaviour:
- Reset (async, _rst=0) forces:
  - state = SLEEP, mem_sleep = 1, mem_rw = 0, mem_addr = 0, mem_din = 0.
  - ack0 = ack1 = 0, rdata = 0.
  - Round-robin pointer = requester 0; idle and wake counters = 0.
  - Reset mid-access aborts without an ack; requesters must re-request.
- All outputs are registered.
- States: SLEEP, WAKE, IDLE, ACCESS.
- SLEEP:
  - mem_sleep = 1.
  - Any req high at an edge -> WAKE; mem_sleep = 0 from the first WAKE cycle.
- WAKE:
  - Stays exactly WAKE_CYCLES cycles (counter), then -> IDLE.
  - Requests are not granted during WAKE.
- IDLE:
  - If any unmasked req is high: pick the winner, latch winner's we/addr/wdata into mem_rw/mem_addr/mem_din, clear the idle counter, go to ACCESS.
  - Otherwise increment the idle counter; when it reaches IDLE_CYCLES (IDLE_CYCLES > 0), go to SLEEP.
- ACCESS:
  - Exactly one cycle; mem_* held stable.
  - At the closing edge: if read, rdata <= mem_dout; assert ack of the winner for one cycle; go to IDLE.
- Arbitration:
  - Only one request -> it wins.
  - Both requests -> the requester named by the pointer wins.
  - After each grant the pointer moves to the other requester (round-robin).
- Ack-cycle mask: during the cycle ackN is high, reqN is ignored, so a held request is never re-granted. A new request is honoured from the next cycle.
- Latency:
  - Request seen in IDLE at cycle t -> ACCESS at t+1 -> ack at t+2.
  - From SLEEP: ack at t+WAKE_CYCLES+3.
  - Minimum spacing between grants is 2 cycles (one IDLE bubble).
- A request arriving in the same cycle the idle counter expires loses to the timeout: -> SLEEP, then wakes normally.
- mem_rw and mem_addr hold their last values in IDLE/WAKE; they are don't-care to the array while mem_sleep = 1.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIORITY_EN.
- Defined: requester 0 always wins contention; the pointer is removed; requester 1 can starve.
- Undefined: round-robin as specified above.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- Reset: assert _rst=0 mid-ACCESS -> immediately mem_sleep=1, ack0=ack1=0, rdata=0; no ack after release.
- Read from sleep (WAKE_CYCLES=2): req0=1, we0=0, addr0=3 at cycle 0, mem_dout=0xA5 -> ack0 high only at cycle 5, rdata=0xA5, mem_addr=3 during ACCESS.
- Write from IDLE: req1=1, we1=1, addr1=0xC, wdata1=0x3C -> ACCESS next cycle with mem_rw=1, mem_addr=0xC, mem_din=0x3C; ack1 two cycles after req.
- Contention: req0 and req1 both held high from IDLE -> ack0, ack1, ack0, ack1 on alternating grants, spaced 2 cycles. With MEM_ARB_FIXED_PRIORITY_EN: ack0 only while req0 held.
- Sleep timeout (IDLE_CYCLES=4): no requests after an ack -> mem_sleep rises on the 5th cycle after ack. A request on the 3rd idle cycle -> no sleep, and the idle counter is cleared.
- Held request: req0 kept high through ack0 with req1=0 -> next grant to requester 0 no earlier than 2 cycles after ack0, never in the ack cycle.
